// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: {b_out, diff} = a - b - b_in, DIGIT bits per clock,
// borrow carried between digits in a register; valid/ready on both sides.

module full_sub (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// state | meaning
// IDLE  | waiting for operands, start_ready high
// BUSY  | one digit per clock, NDIG cycles
// DONE  | result held, res_valid high until res_ready
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             zero,
  output logic             ovf
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
  logic             brw, brw_nxt;
  logic             a_msb, b_msb;
  logic [CW-1:0]    dig_cnt;
  logic             load, step, last;
  logic [DIGIT:0]   bch;
  logic [DIGIT-1:0] d;

  assign bch[0] = brw;
  for (genvar i = 0; i < DIGIT; i++) begin : g_slice
    full_sub u_fs (
      .x  (a_sh[i]),
      .y  (b_sh[i]),
      .bi (bch[i]),
      .d  (d[i]),
      .bo (bch[i+1])
    );
  end
  assign brw_nxt = bch[DIGIT];

  // new digit enters at the MSB end so the final word needs no reordering
  assign res_nxt = (res_sh >> DIGIT) | (WIDTH'(d) << (WIDTH - DIGIT));
  assign last    = (dig_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    step        = 1'b0;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          load      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      brw     <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      dig_cnt <= '0;
      diff    <= '0;
      b_out   <= 1'b0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
    end else if (load) begin
      a_sh    <= a;
      b_sh    <= b;
      brw     <= b_in;
      a_msb   <= a[WIDTH-1];
      b_msb   <= b[WIDTH-1];
      res_sh  <= '0;
      dig_cnt <= CW'(NDIG - 1);
    end else if (step) begin
      a_sh    <= a_sh >> DIGIT;
      b_sh    <= b_sh >> DIGIT;
      brw     <= brw_nxt;
      res_sh  <= res_nxt;
      dig_cnt <= dig_cnt - CW'(1);
      if (last) begin
        diff  <= res_nxt;
        b_out <= brw_nxt;
        zero  <= ~|res_nxt;
        ovf   <= (a_msb ^ b_msb) & (res_nxt[WIDTH-1] ^ a_msb);
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed checks of serial_subtractor at W16/D4 plus exhaustive W4 at D1/D2/D4.

module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic        sv16 = 1'b0, rr16 = 1'b0, bin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        sr16, rv16, bo16, z16, ov16;
  logic [15:0] diff16;

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv16), .start_ready(sr16),
    .a(a16), .b(b16), .b_in(bin16), .res_valid(rv16), .res_ready(rr16),
    .diff(diff16), .b_out(bo16), .zero(z16), .ovf(ov16)
  );

  logic       sv4 = 1'b0, rr4 = 1'b0, bin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [2:0] sr4, rv4, bo4, z4, ov4;
  logic [3:0] d4_1, d4_2, d4_4;

  serial_subtractor #(.WIDTH(4), .DIGIT(1)) dut4_d1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4[0]),
    .a(a4), .b(b4), .b_in(bin4), .res_valid(rv4[0]), .res_ready(rr4),
    .diff(d4_1), .b_out(bo4[0]), .zero(z4[0]), .ovf(ov4[0])
  );
  serial_subtractor #(.WIDTH(4), .DIGIT(2)) dut4_d2 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4[1]),
    .a(a4), .b(b4), .b_in(bin4), .res_valid(rv4[1]), .res_ready(rr4),
    .diff(d4_2), .b_out(bo4[1]), .zero(z4[1]), .ovf(ov4[1])
  );
  serial_subtractor #(.WIDTH(4), .DIGIT(4)) dut4_d4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4[2]),
    .a(a4), .b(b4), .b_in(bin4), .res_valid(rv4[2]), .res_ready(rr4),
    .diff(d4_4), .b_out(bo4[2]), .zero(z4[2]), .ovf(ov4[2])
  );

  task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic binv,
                       input logic [15:0] ed, input logic ebo, input logic ez, input logic eov,
                       input string tag);
    int lat;
    @(negedge clk);
    chk({tag, " start_ready"}, 32'(sr16), 1);
    a16 = av; b16 = bv; bin16 = binv; sv16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv16 = 1'b0; a16 = '1; b16 = '0; bin16 = ~binv;
    lat = 0;
    while (!rv16 && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk({tag, " latency"}, 32'(lat), 4);
    chk({tag, " diff"}, 32'(diff16), 32'(ed));
    chk({tag, " b_out"}, 32'(bo16), 32'(ebo));
    chk({tag, " zero"}, 32'(z16), 32'(ez));
    chk({tag, " ovf"}, 32'(ov16), 32'(eov));
    rr16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rr16 = 1'b0;
    chk({tag, " res_valid drop"}, 32'(rv16), 0);
    chk({tag, " ready again"}, 32'(sr16), 1);
    chk({tag, " diff held"}, 32'(diff16), 32'(ed));
  endtask

  initial begin
    int lat, k, sd;
    logic [2:0] seen;
    int lat4 [3];
    logic [3:0] ea, eb;
    logic ebin, eov;
    logic [4:0] t;
    string tag;

    #2;
    chk("rst start_ready", 32'(sr16), 1);
    chk("rst res_valid", 32'(rv16), 0);
    chk("rst outputs", {12'(diff16), bo16, z16, ov16}, 0);
    chk("rst w4 ready", 32'(sr4), 7);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run16(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, "basic");
    run16(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, "borrow0");
    run16(16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, "borrow_bin");
    run16(16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, "zero");
    run16(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, "ovf_neg");
    run16(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, "ovf_pos");

    // backpressure with ignored start pulses
    @(negedge clk);
    a16 = 16'h00FF; b16 = 16'h000F; bin16 = 1'b1; sv16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv16 = 1'b0;
    lat = 0;
    while (!rv16 && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk("bp latency", 32'(lat), 4);
    for (int i = 0; i < 10; i++) begin
      sv16 = i[0]; a16 = 16'hAAAA; b16 = 16'h1111;
      @(posedge clk);
      @(negedge clk);
      chk("bp res_valid", 32'(rv16), 1);
      chk("bp start_ready", 32'(sr16), 0);
      chk("bp diff", 32'(diff16), 32'h00EF);
      chk("bp b_out", 32'(bo16), 0);
    end
    sv16 = 1'b0; rr16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rr16 = 1'b0;
    chk("bp res_valid drop", 32'(rv16), 0);
    chk("bp ready", 32'(sr16), 1);
    @(posedge clk);
    @(negedge clk);
    chk("bp no queued op", 32'(sr16), 1);

    // reset while processing digit 2
    a16 = 16'h1234; b16 = 16'h0234; bin16 = 1'b0; sv16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv16 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst start_ready", 32'(sr16), 1);
    chk("mid rst res_valid", 32'(rv16), 0);
    chk("mid rst diff", 32'(diff16), 0);
    chk("mid rst flags", {bo16, z16, ov16}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("in rst res_valid", 32'(rv16), 0);
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("after rst res_valid", 32'(rv16), 0);
      chk("after rst ready", 32'(sr16), 1);
    end
    run16(16'hA5A5, 16'h0F0F, 1'b1, 16'h9695, 1'b0, 1'b0, 1'b0, "post_rst");

    // exhaustive W4 against an arithmetic reference
    for (int v = 0; v < 512; v++) begin
      ea = 4'(v); eb = 4'(v >> 4); ebin = v[8];
      t = {1'b0, ea} - {1'b0, eb} - {4'b0, ebin};
      sd = int'($signed(ea)) - int'($signed(eb)) - int'(ebin);
      eov = (sd < -8) || (sd > 7);
      tag = $sformatf("w4 a%0h b%0h bi%0d", ea, eb, ebin);
      @(negedge clk);
      chk({tag, " ready"}, 32'(sr4), 7);
      a4 = ea; b4 = eb; bin4 = ebin; sv4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sv4 = 1'b0; a4 = ~ea; b4 = ~eb;
      seen = '0;
      lat4 = '{0, 0, 0};
      k = 0;
      while (seen != 3'b111 && k < 12) begin
        @(posedge clk); k++; @(negedge clk);
        for (int i = 0; i < 3; i++)
          if (rv4[i] && !seen[i]) begin
            seen[i] = 1'b1;
            lat4[i] = k;
          end
      end
      chk({tag, " done"}, 32'(seen), 7);
      chk({tag, " lat"}, {8'(lat4[2]), 8'(lat4[1]), 8'(lat4[0])}, 32'h010204);
      chk({tag, " diff"}, {d4_4, d4_2, d4_1}, {3{t[3:0]}});
      chk({tag, " b_out"}, 32'(bo4), {3{t[4]}});
      chk({tag, " zero"}, 32'(z4), {3{t[3:0] == 4'd0}});
      chk({tag, " ovf"}, 32'(ov4), {3{eov}});
      rr4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rr4 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
